// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
// Accepts LEN_HI, LEN_LO, LEN payload bytes and an 8-bit additive checksum,
// writes the payload big-endian from address 0 through a single byte write
// port, and raises run only once a complete, checksum-valid image is loaded.
module imem_loader #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              run,
    output logic              busy,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-2:0] words_loaded
);

    // One extra bit so a full-depth image counts to DEPTH without wrapping.
    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_LEN     = 2'b01;
    localparam logic [1:0] E_CSUM    = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    logic [2:0]        state;
    logic [2:0]        state_d;
    logic [1:0]        err_d;
    logic [7:0]        len_hi;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        sum;
    logic [IDLE_W-1:0] idle_cnt;

    logic              xfer;
    logic              loading;
    logic              loading_d;
    logic              start_ok;
    logic [15:0]       len_rx;
    logic              len_bad;
    logic              last_byte;
    logic              timed_out;

    assign xfer      = rx_valid & rx_ready;
    assign loading   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign loading_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                       (state_d == S_DATA)   || (state_d == S_CSUM);
    // start is only honoured when no load is in flight.
    assign start_ok  = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERROR));
    assign len_rx    = {len_hi, rx_data};
    assign len_bad   = (len_rx == 16'd0) || (len_rx[1:0] != 2'b00) || (len_rx > 16'(DEPTH));
    assign last_byte = (byte_cnt + CNT_W'(1)) == len_q;
    // Fires on the edge where the idle counter would step past TIMEOUT.
    assign timed_out = loading && !xfer && (idle_cnt == IDLE_W'(TIMEOUT));

    // Next-state and next error code for the load sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state;
        err_d   = err_code;
        case (state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start_ok) begin
                    state_d = S_LEN_HI;
                    err_d   = E_NONE;
                end
            end
            S_LEN_HI: begin
                if (xfer) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_bad) begin
                        state_d = S_ERROR;
                        err_d   = E_LEN;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && last_byte) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (xfer) begin
                    if (rx_data == sum) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = E_CSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timed_out) begin
            state_d = S_ERROR;
            err_d   = E_TIMEOUT;
        end
    end

    // State, datapath counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            len_q        <= '0;
            byte_cnt     <= '0;
            sum          <= '0;
            idle_cnt     <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            run          <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            err_code     <= E_NONE;
            words_loaded <= '0;
        end else begin
            state    <= state_d;
            err_code <= err_d;
            rx_ready <= loading_d;
            busy     <= loading_d;
            run      <= (state_d == S_RUN);
            error    <= (state_d == S_ERROR);
            mem_we   <= 1'b0;

            if (xfer || (state_d == S_LEN_HI && state != S_LEN_HI)) begin
                idle_cnt <= '0;
            end else if (loading && loading_d) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (start_ok) words_loaded <= '0;

            case (state)
                S_LEN_HI: begin
                    if (xfer) len_hi <= rx_data;
                end
                S_LEN_LO: begin
                    if (xfer && !len_bad) begin
                        len_q    <= CNT_W'(len_rx);
                        byte_cnt <= '0;
                        sum      <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= byte_cnt[ADDR_W-1:0];
                        mem_wdata <= rx_data;
                        sum       <= sum + rx_data;
                        byte_cnt  <= byte_cnt + CNT_W'(1);
                    end
                end
                S_CSUM: begin
                    if (state_d == S_RUN) words_loaded <= (ADDR_W-1)'(len_q >> 2);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a cycle-exact vector table for a good one-word
// image, followed by hand-written sequences for error, backpressure, timeout,
// reload and reset corner cases. Writes are logged from the memory port.
module tb_imem_loader;

    localparam int DEPTH   = 256;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              run;
    logic              busy;
    logic              error;
    logic [1:0]        err_code;
    logic [ADDR_W-2:0] words_loaded;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .run(run), .busy(busy),
        .error(error), .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tb_mem [DEPTH];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    logic [7:0] pay [DEPTH];

    // Memory-side observer: records every write strobe away from the clock edge.
    always @(negedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       busy;
        logic       run;
        logic       err;
        logic [1:0] code;
        logic [6:0] words;
    } vec_t;

    localparam int N_VEC = 9;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".rx_ready"}, 32'(rx_ready), 0);
        check({tag, ".mem_we"}, 32'(mem_we), 0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, ".run"}, 32'(run), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".error"}, 32'(error), 0);
        check({tag, ".err_code"}, 32'(err_code), 0);
        check({tag, ".words_loaded"}, 32'(words_loaded), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget   = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (!rx_ready) check("send_byte.rx_ready", 32'(rx_ready), 1);
        tick();
    endtask

    // Sends a full frame built from pay[0..len-1]; csum_xor corrupts the checksum.
    task automatic send_frame(input int len, input int max_gap, input logic [7:0] csum_xor);
        logic [7:0]  csum;
        logic [15:0] l16;
        csum = 8'h00;
        l16  = 16'(len);
        for (int i = 0; i < len; i++) csum = csum + pay[i];
        send_byte(l16[15:8]);
        send_byte(l16[7:0]);
        for (int i = 0; i < len; i++) begin
            if (max_gap > 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(0, max_gap)) tick();
            end
            send_byte(pay[i]);
        end
        send_byte(csum ^ csum_xor);
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[2] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h01, 8'h22, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[5] = '{1'b0, 1'b1, 8'h18, 1'b1, 1'b1, 8'h02, 8'h18, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[6] = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 8'h03, 8'h20, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0};
        vecs[7] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 7'd1};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 7'd1};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();
        check_reset("post_reset_idle");

        // Good one-word image, cycle by cycle.
        for (int i = 0; i < N_VEC; i++) begin
            start    = vecs[i].start;
            rx_valid = vecs[i].valid;
            rx_data  = vecs[i].data;
            tick();
            check($sformatf("vec%0d.rx_ready", i), 32'(rx_ready), 32'(vecs[i].ready));
            check($sformatf("vec%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d.mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
            end
            check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d.run", i), 32'(run), 32'(vecs[i].run));
            check($sformatf("vec%0d.error", i), 32'(error), 32'(vecs[i].err));
            check($sformatf("vec%0d.err_code", i), 32'(err_code), 32'(vecs[i].code));
            check($sformatf("vec%0d.words", i), 32'(words_loaded), 32'(vecs[i].words));
        end
        start    = 1'b0;
        rx_valid = 1'b0;

        // Bad checksum: four writes, then error code 10; restart recovers.
        pay[0] = 8'h00; pay[1] = 8'h22; pay[2] = 8'h18; pay[3] = 8'h20;
        clear_log();
        pulse_start();
        send_frame(4, 0, 8'h01);
        check("badcsum.writes", 32'(wr_addr.size()), 4);
        check("badcsum.error", 32'(error), 1);
        check("badcsum.err_code", 32'(err_code), 2);
        check("badcsum.run", 32'(run), 0);
        check("badcsum.busy", 32'(busy), 0);
        pulse_start();
        check("badcsum.restart_error", 32'(error), 0);
        check("badcsum.restart_code", 32'(err_code), 0);
        check("badcsum.restart_busy", 32'(busy), 1);
        send_frame(4, 0, 8'h00);
        check("badcsum.recover_run", 32'(run), 1);
        check("badcsum.recover_words", 32'(words_loaded), 1);

        // Bad lengths: 6 (not a word multiple) and 260 (above depth).
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h06);
        rx_valid = 1'b0;
        check("len6.error", 32'(error), 1);
        check("len6.err_code", 32'(err_code), 1);
        check("len6.run", 32'(run), 0);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        rx_valid = 1'b0;
        check("len260.error", 32'(error), 1);
        check("len260.err_code", 32'(err_code), 1);
        repeat (3) tick();
        check("badlen.no_writes", 32'(wr_addr.size()), 0);

        // Full-depth image: 256 bytes, addresses 0..255 without wrap.
        for (int i = 0; i < DEPTH; i++) pay[i] = 8'((i * 37 + 5) & 255);
        clear_log();
        pulse_start();
        send_frame(256, 0, 8'h00);
        check("len256.run", 32'(run), 1);
        check("len256.words", 32'(words_loaded), 64);
        check("len256.writes", 32'(wr_addr.size()), 256);
        if (wr_addr.size() == 256) begin
            for (int i = 0; i < DEPTH; i++) begin
                check($sformatf("len256.addr%0d", i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("len256.data%0d", i), 32'(wr_data[i]), 32'(pay[i]));
            end
        end

        // Reload from RUN with random rx_valid gaps; new image overwrites the old.
        for (int i = 0; i < 8; i++) pay[i] = 8'(8'hA0 + i * 3);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("reload.run_drop", 32'(run), 0);
        check("reload.busy", 32'(busy), 1);
        check("reload.words_clear", 32'(words_loaded), 0);
        send_frame(8, 10, 8'h00);
        check("gaps.run", 32'(run), 1);
        check("gaps.words", 32'(words_loaded), 2);
        check("gaps.writes", 32'(wr_addr.size()), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gaps.mem%0d", i), 32'(tb_mem[i]), 32'(8'hA0 + i * 3));
        end
        check("gaps.mem8_untouched", 32'(tb_mem[8]), 32'((8 * 37 + 5) & 255));

        // start during DATA is ignored.
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h11);
        start = 1'b1;
        send_byte(8'h22);
        start = 1'b0;
        check("start_in_data.busy", 32'(busy), 1);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hAA);
        rx_valid = 1'b0;
        check("start_in_data.run", 32'(run), 1);
        check("start_in_data.writes", 32'(wr_addr.size()), 4);
        if (wr_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("start_in_data.addr%0d", i), 32'(wr_addr[i]), 32'(i));
                check($sformatf("start_in_data.data%0d", i), 32'(wr_data[i]), 32'(8'h11 * (i + 1)));
            end
        end

        // Timeout after two payload bytes: error exactly after TIMEOUT+1 idle edges.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h02);
        rx_valid = 1'b0;
        repeat (TIMEOUT) tick();
        check("timeout.early_error", 32'(error), 0);
        check("timeout.early_busy", 32'(busy), 1);
        tick();
        check("timeout.error", 32'(error), 1);
        check("timeout.err_code", 32'(err_code), 3);
        check("timeout.busy", 32'(busy), 0);
        check("timeout.rx_ready", 32'(rx_ready), 0);

        // Reset in the middle of DATA.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h5A);
        send_byte(8'h6B);
        send_byte(8'h7C);
        rx_data = 8'h8D;
        rst_n   = 1'b0;
        tick();
        check_reset("mid_data_reset");
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("after_reset.busy", 32'(busy), 0);
        check("after_reset.rx_ready", 32'(rx_ready), 0);
        pay[0] = 8'h00; pay[1] = 8'h22; pay[2] = 8'h18; pay[3] = 8'h20;
        pulse_start();
        send_frame(4, 0, 8'h00);
        check("after_reset.run", 32'(run), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
